fb_arbiter: RTL and testbench

Single-port framebuffer RAM scheduler between the VGA scan-out path and the game logic. Display reads get absolute priority every cycle they are requested. Game writes are buffered in a small FIFO and drained into idle RAM cycles. A hardware clear engine sweeps the whole framebuffer with one colour using the same idle cycles.

---
 rtl/vga_pkg.sv | 16 +
 rtl/fb_wr_fifo.sv | 49 ++++
 rtl/fb_arbiter.sv | 145 ++++++++++++++
 tb/tb_fb_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA framebuffer types and constants.
// Used by fb_arbiter and its write FIFO.
package vga_pkg;

  localparam int PIXEL_W   = 12;
  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } fb_arb_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO buffering game writes for the framebuffer arbiter.
// Push is ignored when full, pop is ignored when empty.
module fb_wr_fifo #(
  parameter int W     = 27,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM port scheduler: display read > clear > FIFO write.
// Define FB_ARB_STATS_EN to add the stall_cnt output.
module fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 12,
  parameter int FB_WORDS = 19200,
  parameter int DEPTH    = 4
) (
  input  logic              vgaclk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int FW = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FB_WORDS - 1);

  fb_arb_state_e     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              done_q, done_d;
  logic              dvalid_q;

  logic [FW-1:0]     head;
  logic              f_full;
  logic              f_empty;
  logic              push;
  logic              pop;

  assign wr_ready   = !f_full && !rst;
  assign push       = wr_valid && wr_ready;
  assign clr_busy   = (state_q == CLEAR);
  assign clr_done   = done_q;
  assign disp_valid = dvalid_q;
  assign disp_data  = dvalid_q ? mem_rdata : '0;

  fb_wr_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (vgaclk),
    .rst   (rst),
    .push  (push),
    .din   ({wr_addr, wr_data}),
    .pop   (pop),
    .dout  (head),
    .full  (f_full),
    .empty (f_empty)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    color_d   = color_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (disp_req) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else if (state_q == CLEAR) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = color_q;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end
      end else if (!f_empty) begin
        // FIFO only drains outside a clear so queued writes land last
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head[FW-1:DATA_W];
        mem_wdata = head[DATA_W-1:0];
        pop       = 1'b1;
      end
      if (state_q == IDLE && clr_start) begin
        state_d = CLEAR;
        ptr_d   = '0;
        color_d = clr_color;
      end
    end
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      color_q  <= '0;
      done_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      color_q  <= color_d;
      done_q   <= done_d;
      dvalid_q <= disp_req;
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (wr_valid && !wr_ready
                 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed self-checking bench for fb_arbiter with a behavioural RAM.
// Define FB_ARB_STATS_EN to also exercise stall_cnt.
module tb_fb_arbiter;

  localparam int AW = 15;
  localparam int DW = 12;
  localparam int FBW = 19200;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef FB_ARB_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ram [0:32767];
  int            wcnt = 0;
  int            w7_cnt = 0;
  logic [DW-1:0] w7_log [0:7];

  always #5 clk = ~clk;

  fb_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .FB_WORDS (FBW),
    .DEPTH    (4)
  ) dut (
    .vgaclk     (clk),
    .rst        (rst),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .clr_start  (clr_start),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef FB_ARB_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  // Behavioural single-port RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        wcnt = wcnt + 1;
        if (mem_addr == 15'd7) begin
          w7_log[w7_cnt[2:0]] = mem_wdata;
          w7_cnt = w7_cnt + 1;
        end
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    disp_req = 0; disp_addr = '0;
    wr_valid = 0; wr_addr = '0; wr_data = '0;
    clr_start = 0; clr_color = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (disp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_disp_valid got=%b exp=0", disp_valid);
    end
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_clr got=%b%b exp=00", clr_busy, clr_done);
    end
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_wr_ready got=%b exp=0", wr_ready);
    end
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_mem_en_we got=%b%b exp=00", mem_en, mem_we);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL rst_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_rst_wr_ready got=%b exp=1", wr_ready);
    end
  endtask

  task automatic test_disp_read();
    // seed RAM through the FIFO path
    @(negedge clk);
    wr_valid = 1; wr_addr = 15'd5; wr_data = 12'hF00;
    @(negedge clk);
    wr_addr = 15'd19200; wr_data = 12'h555;
    @(negedge clk);
    wr_valid = 0;
    @(negedge clk);
    @(negedge clk);
    disp_req = 1; disp_addr = 15'd5;
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'd5) begin
      failures++;
      $display("FAIL disp_port got en=%b we=%b a=%0d exp en=1 we=0 a=5",
               mem_en, mem_we, mem_addr);
    end
    @(negedge clk);
    disp_req = 0;
    checks++;
    if (disp_valid !== 1'b1 || disp_data !== 12'hF00) begin
      failures++;
      $display("FAIL disp_data got v=%b d=%h exp v=1 d=f00",
               disp_valid, disp_data);
    end
    @(negedge clk);
    checks++;
    if (disp_valid !== 1'b0 || disp_data !== 12'h000) begin
      failures++;
      $display("FAIL disp_idle got v=%b d=%h exp v=0 d=000",
               disp_valid, disp_data);
    end
  endtask

  task automatic test_fifo_full();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int bad;
    disp_req = 1; disp_addr = 15'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_valid = 1; wr_addr = AW'(i); wr_data = DW'(i + 1);
      #1;
      checks++;
      if (wr_ready !== 1'b1 || mem_we !== 1'b0) begin
        failures++;
        $display("FAIL push%0d got rdy=%b we=%b exp rdy=1 we=0",
                 i, wr_ready, mem_we);
      end
    end
    @(negedge clk);
    wr_addr = 15'd4; wr_data = 12'd5;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_stall got rdy=%b exp=0", wr_ready);
    end
    @(negedge clk);
    wr_valid = 0; disp_req = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      ea = AW'(i);
      ed = DW'(i + 1);
      if (mem_en !== 1'b1 || mem_we !== 1'b1
          || mem_addr !== ea || mem_wdata !== ed
          || wr_ready !== (i != 0)) begin
        bad++;
        $display("FAIL drain%0d got a=%0d d=%h rdy=%b exp a=%0d d=%h",
                 i, mem_addr, mem_wdata, wr_ready, ea, ed);
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) failures++;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin
      failures++;
      $display("FAIL drain_idle got en=%b exp=0", mem_en);
    end
    checks++;
    if (ram[0] !== 12'd1 || ram[3] !== 12'd4 || ram[4] !== 12'd0) begin
      failures++;
      $display("FAIL drain_ram got %h %h %h exp 001 004 000",
               ram[0], ram[3], ram[4]);
    end
  endtask

  task automatic test_clear();
    int busy_n = 0;
    int done_n = 0;
    int bad = 0;
    @(negedge clk);
    clr_start = 1; clr_color = 12'h0F0;
    @(negedge clk);
    clr_start = 0; clr_color = 12'h000;
    for (int i = 0; i < 20010; i++) begin
      if (clr_busy) busy_n++;
      if (clr_done) done_n++;
      if (!clr_busy && busy_n > 0) break;
      clr_start = (i == 1000);
      clr_color = (i == 1000) ? 12'hFFF : 12'h000;
      @(negedge clk);
    end
    clr_start = 0;
    repeat (3) begin
      @(negedge clk);
      if (clr_done) done_n++;
    end
    checks++;
    if (busy_n != FBW) begin
      failures++;
      $display("FAIL clr_busy_len got=%0d exp=%0d", busy_n, FBW);
    end
    checks++;
    if (done_n != 1) begin
      failures++;
      $display("FAIL clr_done_pulses got=%0d exp=1", done_n);
    end
    for (int a = 0; a < FBW; a++)
      if (ram[a] !== 12'h0F0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clr_fill got bad_words=%0d exp=0", bad);
    end
    checks++;
    if (ram[FBW] !== 12'h555) begin
      failures++;
      $display("FAIL clr_bound got=%h exp=555", ram[FBW]);
    end
  endtask

  task automatic test_clear_write();
    int base;
    int n = 0;
    base = w7_cnt;
    @(negedge clk);
    clr_start = 1; clr_color = 12'h00F;
    @(negedge clk);
    clr_start = 0;
    @(negedge clk);
    wr_valid = 1; wr_addr = 15'd7; wr_data = 12'hABC;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_clr_push got rdy=%b exp=1", wr_ready);
    end
    @(negedge clk);
    wr_valid = 0;
    while (clr_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL clr2_timeout got busy=%b exp=0", clr_busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (w7_cnt - base != 2) begin
      failures++;
      $display("FAIL w7_count got=%0d exp=2", w7_cnt - base);
    end
    checks++;
    if (w7_log[base[2:0]] !== 12'h00F
        || w7_log[3'(base + 1)] !== 12'hABC) begin
      failures++;
      $display("FAIL w7_order got %h,%h exp 00f,abc",
               w7_log[base[2:0]], w7_log[3'(base + 1)]);
    end
    checks++;
    if (ram[7] !== 12'hABC) begin
      failures++;
      $display("FAIL w7_final got=%h exp=abc", ram[7]);
    end
  endtask

  task automatic test_reset_mid_clear();
    int snap;
    @(negedge clk);
    clr_start = 1; clr_color = 12'h333;
    @(negedge clk);
    clr_start = 0;
    wr_valid = 1; wr_addr = 15'd500; wr_data = 12'hAAA;
    @(negedge clk);
    wr_addr = 15'd501; wr_data = 12'hBBB;
    @(negedge clk);
    wr_valid = 0;
    // pointer equals 100 at the 101st negedge after start
    repeat (98) @(negedge clk);
    rst = 1;
    snap = wcnt;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_cycle_en got=%b exp=0", mem_en);
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL post_rst got busy=%b en=%b exp 0 0",
               clr_busy, mem_en);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (wcnt != snap) begin
      failures++;
      $display("FAIL post_rst_writes got=%0d exp=0", wcnt - snap);
    end
    checks++;
    if (ram[99] !== 12'h333 || ram[100] !== 12'h00F
        || ram[500] !== 12'h00F || ram[501] !== 12'h00F) begin
      failures++;
      $display("FAIL rst_ram got %h %h %h %h exp 333 00f 00f 00f",
               ram[99], ram[100], ram[500], ram[501]);
    end
  endtask

`ifdef FB_ARB_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    disp_req = 1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_addr = AW'(i + 40); wr_data = DW'(i);
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    wr_valid = 0;
    checks++;
    if (stall_cnt !== 16'd10) begin
      failures++;
      $display("FAIL stall_cnt got=%0d exp=10", stall_cnt);
    end
    disp_req = 0;
    repeat (6) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_disp_read();
    test_fifo_full();
    test_clear();
    test_clear_write();
    test_reset_mid_clear();
`ifdef FB_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
